// File: rtl/pixel_stream_checker.sv
// Joins two pixel streams, compares them pair by pair, and reports a per-frame
// verdict with mismatch count, first-failure capture and a stall timeout.
module pixel_stream_checker #(
    parameter int DATA_W  = 20,
    parameter int NUM_PIX = 4096,
    parameter int CNT_W   = 13,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic              err_pulse,
    output logic [CNT_W-1:0]  mismatch_cnt,
    output logic [CNT_W-1:0]  pix_idx,
    output logic [CNT_W-1:0]  first_err_idx,
    output logic [DATA_W-1:0] first_err_a,
    output logic [DATA_W-1:0] first_err_b
);

    localparam int STALL_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]   LAST_IDX   = CNT_W'(NUM_PIX - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    logic [STALL_W-1:0] stall_cnt;
    logic               accept;
    logic               mismatch;

    // Both streams are consumed together or not at all.
    assign accept   = (state == RUN) && a_valid && b_valid;
    assign a_ready  = accept;
    assign b_ready  = accept;
    assign mismatch = (a_data != b_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            stall_cnt     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            err_pulse     <= 1'b0;
            mismatch_cnt  <= '0;
            pix_idx       <= '0;
            first_err_idx <= '0;
            first_err_a   <= '0;
            first_err_b   <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b0;
            end else if (start && state != RUN) begin
                state         <= RUN;
                busy          <= 1'b1;
                done          <= 1'b0;
                pass          <= 1'b0;
                timeout       <= 1'b0;
                stall_cnt     <= '0;
                mismatch_cnt  <= '0;
                pix_idx       <= '0;
                first_err_idx <= '0;
                first_err_a   <= '0;
                first_err_b   <= '0;
            end else if (state == RUN) begin
                if (accept) begin
                    stall_cnt <= '0;
                    pix_idx   <= pix_idx + CNT_W'(1);
                    if (mismatch) begin
                        err_pulse <= 1'b1;
                        if (mismatch_cnt != CNT_MAX) begin
                            mismatch_cnt <= mismatch_cnt + CNT_W'(1);
                        end
                        // A zero count means no earlier failure in this frame.
                        if (mismatch_cnt == '0) begin
                            first_err_idx <= pix_idx;
                            first_err_a   <= a_data;
                            first_err_b   <= b_data;
                        end
                    end
                    if (pix_idx == LAST_IDX) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= !mismatch && (mismatch_cnt == '0);
                    end
                end else if (stall_cnt == STALL_LAST) begin
                    state   <= DONE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    timeout <= 1'b1;
                    pass    <= 1'b0;
                end else begin
                    stall_cnt <= stall_cnt + STALL_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/pixel_stream_checker.md
Name: pixel_stream_checker

Overview:
- Synthesizable self-check controller for the CFA convolution output path.
- Sequences a pairwise comparison of two pixel streams: the RTL convolution output (stream A) and a golden-model stream B from ROM or a DMA reader.
- Joins both streams, compares one pair per accepted beat, counts mismatches, captures the first failure, enforces a stall timeout, and reports pass/fail after a full frame.
- Sits after the convolution datapath; used on-chip and in regression benches in place of file-based comparison.

Parameters:
DATA_W, 20, pixel width (12-bit pixel + 8 fractional/growth bits)
NUM_PIX, 4096, pixels per frame to compare (>=1)
CNT_W, 13, width of pixel index and mismatch counter; must satisfy 2^CNT_W > NUM_PIX
TIMEOUT, 1024, max consecutive RUN cycles with no accepted pair before abort (>=2)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; begins a frame check when IDLE or DONE
abort  in  1  synchronous; forces return to IDLE
a_valid  in  1  stream A beat valid
a_data  in  DATA_W  stream A pixel
a_ready  out  1  stream A accept
b_valid  in  1  stream B beat valid
b_data  in  DATA_W  stream B pixel
b_ready  out  1  stream B accept
busy  out  1  high in RUN
done  out  1  high in DONE (level)
pass  out  1  valid when done: 1 = zero mismatches and no timeout
timeout  out  1  valid when done: frame ended by stall timeout
err_pulse  out  1  one-cycle pulse per mismatching pair
mismatch_cnt  out  CNT_W  saturating mismatch count
pix_idx  out  CNT_W  pairs accepted this frame
first_err_idx  out  CNT_W  index of first mismatch
first_err_a  out  DATA_W  A value at first mismatch
first_err_b  out  DATA_W  B value at first mismatch

Behaviour:
- Reset (async, rst_n=0): state IDLE; every output 0, including pass.
- FSM states: IDLE, RUN, DONE.
  - IDLE --start--> RUN
  - RUN --(last pair accepted | stall timeout)--> DONE
  - DONE --start--> RUN
  - any --abort--> IDLE; abort has priority over start.
- Entering RUN clears pix_idx, mismatch_cnt, first_err_*, timeout, pass and the stall counter.
- start while in RUN is ignored.
- Join handshake: a_ready = b_ready = (state==RUN) & a_valid & b_valid.
  - A pair is accepted only when both are valid; neither stream is ever consumed alone.
  - Ready is combinational from valid; upstream must not make valid depend on ready.
- Compare is registered.
  - On an accepted beat, mismatch = (a_data != b_data), compared over the full DATA_W width.
  - err_pulse asserts the following cycle, for one cycle.
- mismatch_cnt increments on each mismatch and saturates at 2^CNT_W-1.
- first_err_idx/a/b latch only on the first mismatch of the frame, then hold until the next start.
- pix_idx increments on every accepted pair; first accepted pair has index 0.
- Completion on the accept of pair NUM_PIX-1:
  - The next cycle: state DONE, done=1, busy=0.
  - pass = (no mismatch including this last pair).
  - err_pulse for the last pair coincides with done rising.
- Stall counter:
  - Increments each RUN cycle with no accept; resets to 0 on accept.
  - When it reaches TIMEOUT: DONE, timeout=1, pass=0.
- Simultaneous accept and timeout cannot happen, because an accept resets the counter.
- In DONE: ready=0 and all results hold.
- abort mid-frame: IDLE next cycle; results hold their last values, done=0, busy=0; the next start clears them.
- Async reset mid-frame clears everything immediately; no partial result is retained.

Test Plan:
- Identical streams, NUM_PIX=16, both valid every cycle, data 0..15:
  - a_ready/b_ready high for 16 cycles.
  - done rises 1 cycle after the 16th accept.
  - pass=1, mismatch_cnt=0, pix_idx=16, err_pulse never asserts.
- Mismatches at idx 3 (A=0x00ABC, B=0x00ABD) and idx 9:
  - err_pulse pulses twice, mismatch_cnt=2, pass=0.
  - first_err_idx=3, first_err_a=0x00ABC, first_err_b=0x00ABD.
- Skewed streams: A valid every cycle, B valid every 3rd cycle:
  - Accepts only when B is valid; no A beat is dropped.
  - 16 pairs accepted in 48 cycles; result matches the first scenario.
- Stall with TIMEOUT=8: B stops after pair 5 →
  - 8 cycles later: done=1, timeout=1, pass=0, pix_idx=5.
- Saturation with CNT_W=4, NUM_PIX=15, all pairs mismatch:
  - mismatch_cnt stops at 15 without wrapping.
  - start after DONE clears the count and rechecks.
- abort at pix_idx=7, then rst_n low mid-frame:
  - abort → IDLE next cycle, ready=0.
  - Reset → all outputs 0 asynchronously.
  - A new start runs a clean frame with pass=1.
